// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller wrapped around a simple dual-port RAM with a
// registered read port. Pointers, occupancy, status flags and error pulses live here.

module dpram_rw #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 256,
   localparam int AW = $clog2(DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Output register keeps the last word while rd_en is low; only the register is reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

module fifo_sync_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int DATA_DEPTH  = 256,
   parameter int AFULL_LEVEL = DATA_DEPTH - 4,
   localparam int AW = $clog2(DATA_DEPTH),
   localparam int CW = AW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [CW-1:0]         count,
   output logic                  overflow,
   output logic                  underflow
);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_valid_q, pop_valid_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          push_acc, pop_acc;

   assign full        = (count_q == CW'(DATA_DEPTH));
   assign empty       = (count_q == '0);
   assign almost_full = (count_q >= CW'(AFULL_LEVEL));

   // Acceptance is gated by the registered flags, so a same-address
   // read/write (only possible when empty or full) never reaches the RAM.
   always_comb begin
      push_acc    = push & ~full;
      pop_acc     = pop & ~empty;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_acc) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      pop_valid_d = pop_acc;
      overflow_d  = push & full;
      underflow_d = pop & empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pop_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pop_valid_q <= pop_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   dpram_rw #(
      .DATA_WIDTH(DATA_WIDTH),
      .DATA_DEPTH(DATA_DEPTH)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (push_acc),
      .wr_addr(wr_ptr_q),
      .wr_data(push_data),
      .rd_en  (pop_acc),
      .rd_addr(rd_ptr_q),
      .rd_data(pop_data)
   );

   assign count     = count_q;
   assign pop_valid = pop_valid_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
Synchronous single-clock FIFO built around one dpram_rw instance.
- Owns the write pointer, read pointer and occupancy count.
- Drives the dpram_rw write port from push requests and the read port from pop requests.
- Provides full/empty/almost-full status and error pulses.
- Used wherever a stream must be buffered between producer and consumer logic in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word; passed to dpram_rw.
DATA_DEPTH, 256, number of entries; must be a power of two, >= 2; passed to dpram_rw.
AFULL_LEVEL, DATA_DEPTH-4, almost_full asserts when count >= this value; legal range 1..DATA_DEPTH.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
push  input  1  write request this cycle.
push_data  input  DATA_WIDTH  word to write.
pop  input  1  read request this cycle.
pop_data  output  DATA_WIDTH  read word; meaningful only while pop_valid=1.
pop_valid  output  1  pop_data holds the word for the pop accepted on the previous cycle.
full  output  1  count == DATA_DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AFULL_LEVEL.
count  output  $clog2(DATA_DEPTH)+1  current occupancy, 0..DATA_DEPTH.
overflow  output  1  one-cycle pulse: push requested while full.
underflow  output  1  one-cycle pulse: pop requested while empty.

Behaviour:
- Reset (rst=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, overflow=0, underflow=0.
  - Therefore empty=1, full=0, almost_full=0 (for AFULL_LEVEL>=1).
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored entries and any pending pop_valid.
  - rst is forwarded to dpram_rw.
- Pointers:
  - wr_ptr and rd_ptr are each $clog2(DATA_DEPTH) bits and wrap naturally from DATA_DEPTH-1 to 0.
  - count is a separate $clog2(DATA_DEPTH)+1-bit register.
- Acceptance uses this cycle's registered flags only:
  - push_acc = push & !full.
  - pop_acc = pop & !empty.
- Write port:
  - wr_en = push_acc, wr_addr = wr_ptr, wr_data = push_data (combinational).
  - wr_ptr increments on push_acc.
- Read port:
  - rd_en = pop_acc, rd_addr = rd_ptr (combinational).
  - rd_ptr increments on pop_acc.
- Read latency is 1 cycle:
  - pop_valid <= pop_acc.
  - pop_data = dpram rd_data, which holds its value while rd_en=0.
- Count update:
  - push_acc only: +1.
  - pop_acc only: -1.
  - both or neither: unchanged.
- Simultaneous push and pop:
  - While full: pop accepted, push rejected, overflow pulses; count becomes DATA_DEPTH-1.
  - While empty: push accepted, pop rejected, underflow pulses; count becomes 1.
  - Otherwise: both accepted, count unchanged.
- Read/write same-address hazard: rd_addr == wr_addr with both enables high happens only when empty or full. In both cases one request is rejected, so the RAM never sees a same-address read/write collision.
- Flags full, empty and almost_full are combinational compares on count. They reflect state after the last edge.
- overflow and underflow:
  - overflow <= push & full; underflow <= pop & empty.
  - Each is high for exactly one cycle per offending request.
  - The rejected operation has no other effect.
- FIFO order is strict: words pop in push order across pointer wrap.

Test Plan:
1. Reset then idle 3 cycles -> empty=1, full=0, count=0, pop_valid=0, overflow=0, underflow=0.
2. Push 0xde, 0xad, 0xbe, 0xef on consecutive cycles, then pop 4 consecutive cycles -> count peaks at 4; pop_valid high 4 cycles, one cycle after each pop; pop_data = 0xde, 0xad, 0xbe, 0xef; then empty=1.
3. Push 256 words (i%2 ? 0xa5 : 0x5a) -> full=1 and count=256 after the last; almost_full first high when count reaches 252. A 257th push with 0x00 -> overflow one cycle, count stays 256. Then pop all 256 -> data matches pattern, empty=1.
4. Pop while empty -> underflow one cycle, pop_valid stays 0, count=0. Push+pop in the same cycle while empty with 0x3c -> count=1, underflow pulses; next pop returns 0x3c.
5. Fill to 256, then push 0x11 + pop in the same cycle -> pop accepted (returns first word), push dropped, overflow pulses, count=255. Fill to 128, then 300 cycles of simultaneous push of $random data + pop -> count stays 128, output sequence matches a reference queue across pointer wrap.
6. Push 10 words, assert rst for one cycle concurrently with push+pop -> next cycle count=0, empty=1, pop_valid=0. Subsequent push 0x77 / pop returns 0x77.
